// File: rtl/buspirate_top.sv
// Bus Pirate FPGA top: slave side of the MCU async parallel bus.
// Register bank written via synchronized strobes, read combinationally.
module buspirate_top #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter logic [MC_DATA_WIDTH-1:0] ID_VALUE = 16'h5055
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_oe,
  input  logic                     mc_ce,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  inout  wire  [MC_DATA_WIDTH-1:0] mc_data
);

  localparam int NREG = 1 << MC_ADD_WIDTH;
  localparam logic [MC_ADD_WIDTH-1:0] ID_ADDR = '1;

  logic [1:0]               ce_sync;
  logic [1:0]               we_sync;
  logic                     ws;
  logic                     ws_q;
  logic                     commit;
  logic                     rd_en;
  logic [MC_ADD_WIDTH-1:0]  hold_add;
  logic [MC_DATA_WIDTH-1:0] hold_data;
  logic [MC_DATA_WIDTH-1:0] rd_data;
  logic [MC_DATA_WIDTH-1:0] regs [NREG];

  // two-flop synchronizers for the write-side strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ce_sync <= 2'b11;
      we_sync <= 2'b11;
    end else begin
      ce_sync <= {ce_sync[0], mc_ce};
      we_sync <= {we_sync[0], mc_we};
    end
  end

  assign ws     = !ce_sync[1] && !we_sync[1];
  assign commit = ws_q && !ws;

  // track strobe history and hold the latest addr/data seen while writing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ws_q      <= 1'b0;
      hold_add  <= '0;
      hold_data <= '0;
    end else begin
      ws_q <= ws;
      if (ws) begin
        hold_add  <= mc_add;
        hold_data <= mc_data;
      end
    end
  end

  // register bank; top address is a fixed ID that writes cannot change
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == NREG - 1) ? ID_VALUE : '0;
      end
    end else if (commit && (hold_add != ID_ADDR)) begin
      regs[hold_add] <= hold_data;
    end
  end

  // read mux with bypass so a read during the commit cycle sees new data
  always_comb begin
    rd_data = regs[mc_add];
    if (commit && (hold_add == mc_add) && (mc_add != ID_ADDR)) begin
      rd_data = hold_data;
    end
  end

  assign rd_en   = !mc_ce && !mc_oe && mc_we;
  assign mc_data = rd_en ? rd_data : 'z;

endmodule

// File: tb/tb_buspirate_top.sv
// Self-checking bench for buspirate_top.
// Vector table plus hand sequences, expectations through a scoreboard queue.
module tb_buspirate_top;

  logic        clk;
  logic        rst_n;
  logic        mc_oe;
  logic        mc_ce;
  logic        mc_we;
  logic [5:0]  mc_add;
  logic [15:0] drv;
  logic        drv_en;
  wire  [15:0] mc_data;

  int n_cmp;
  int n_bad;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];

  typedef struct {
    bit          wr;
    logic [5:0]  a;
    logic [15:0] d;
  } vec_t;

  vec_t vecs[$];

  assign mc_data = drv_en ? drv : 'z;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup pu (mc_data[i]);
  end

  buspirate_top dut (
    .clock   (clk),
    .reset   (rst_n),
    .mc_oe   (mc_oe),
    .mc_ce   (mc_ce),
    .mc_we   (mc_we),
    .mc_add  (mc_add),
    .mc_data (mc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_push(input string nm, input logic [15:0] e);
    sb_t s;
    s.name = nm;
    s.exp  = e;
    sb.push_back(s);
  endtask

  task automatic sample_pop(input logic [15:0] act);
    sb_t s;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %h required an expectation", act);
    end else begin
      s = sb.pop_front();
      if (act !== s.exp) begin
        n_bad++;
        $display("FAIL %s: got %h required %h", s.name, act, s.exp);
      end
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    mc_add = a;
    drv    = d;
    drv_en = 1'b1;
    mc_oe  = 1'b1;
    mc_ce  = 1'b0;
    mc_we  = 1'b0;
    repeat (5) @(negedge clk);
    mc_ce = 1'b1;
    mc_we = 1'b1;
    repeat (4) @(negedge clk);
    drv_en = 1'b0;
  endtask

  task automatic bus_read(input string nm, input logic [5:0] a,
                          input logic [15:0] e);
    @(negedge clk);
    drv_en = 1'b0;
    mc_add = a;
    mc_we  = 1'b1;
    mc_ce  = 1'b0;
    mc_oe  = 1'b0;
    expect_push(nm, e);
    @(posedge clk);
    #1;
    sample_pop(mc_data);
    @(negedge clk);
    mc_ce = 1'b1;
    mc_oe = 1'b1;
  endtask

  task automatic add_vec(input bit wr, input logic [5:0] a,
                         input logic [15:0] d);
    vec_t v;
    v.wr = wr;
    v.a  = a;
    v.d  = d;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    mc_oe  = 1'b1;
    mc_ce  = 1'b1;
    mc_we  = 1'b1;
    mc_add = '0;
    drv    = '0;
    drv_en = 1'b0;

    // wr=0 rows are reads whose d is the required value
    add_vec(1, 6'h00, 16'hAA55);
    add_vec(0, 6'h00, 16'hAA55);
    add_vec(1, 6'h05, 16'h1234);
    add_vec(1, 6'h06, 16'hBEEF);
    add_vec(0, 6'h05, 16'h1234);
    add_vec(0, 6'h06, 16'hBEEF);
    add_vec(0, 6'h00, 16'hAA55);
    add_vec(1, 6'h3F, 16'hFFFF);
    add_vec(0, 6'h3F, 16'h5055);
    add_vec(1, 6'h20, 16'h0001);
    add_vec(0, 6'h20, 16'h0001);
    add_vec(0, 6'h1F, 16'h0000);
    add_vec(1, 6'h05, 16'h8001);
    add_vec(0, 6'h05, 16'h8001);
    add_vec(0, 6'h06, 16'hBEEF);

    repeat (3) @(negedge clk);
    #1;
    expect_push("idle_in_reset", 16'hFFFF);
    sample_pop(mc_data);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    bus_read("reset_reg00", 6'h00, 16'h0000);
    bus_read("reset_id", 6'h3F, 16'h5055);

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].a, vecs[i].d);
      end else begin
        bus_read($sformatf("vec%0d_rd_%h", i, vecs[i].a),
                 vecs[i].a, vecs[i].d);
      end
    end

    // CE high, OE low: bus must be released (pullup) with reg00=AA55
    @(negedge clk);
    mc_add = 6'h00;
    mc_ce  = 1'b1;
    mc_oe  = 1'b0;
    mc_we  = 1'b1;
    expect_push("ce_high_released", 16'hFFFF);
    @(posedge clk);
    #1;
    sample_pop(mc_data);
    @(negedge clk);
    drv    = 16'h1234;
    drv_en = 1'b1;
    expect_push("ce_high_no_contend", 16'h1234);
    @(posedge clk);
    #1;
    sample_pop(mc_data);
    @(negedge clk);
    drv_en = 1'b0;
    mc_oe  = 1'b1;

    // CE, OE and WE all low: a write, bus stays bench-driven
    @(negedge clk);
    mc_add = 6'h0A;
    drv    = 16'h0F0F;
    drv_en = 1'b1;
    mc_ce  = 1'b0;
    mc_we  = 1'b0;
    mc_oe  = 1'b0;
    repeat (3) @(negedge clk);
    expect_push("all_low_not_driven", 16'h0F0F);
    @(posedge clk);
    #1;
    sample_pop(mc_data);
    @(negedge clk);
    mc_ce = 1'b1;
    mc_we = 1'b1;
    mc_oe = 1'b1;
    repeat (4) @(negedge clk);
    drv_en = 1'b0;
    bus_read("all_low_commit", 6'h0A, 16'h0F0F);

    // WE alone ends the write while CE stays low
    @(negedge clk);
    mc_add = 6'h11;
    drv    = 16'h3C3C;
    drv_en = 1'b1;
    mc_ce  = 1'b0;
    mc_we  = 1'b0;
    repeat (4) @(negedge clk);
    mc_we = 1'b1;
    repeat (3) @(negedge clk);
    drv_en = 1'b0;
    mc_oe  = 1'b0;
    expect_push("we_only_end", 16'h3C3C);
    @(posedge clk);
    #1;
    sample_pop(mc_data);
    @(negedge clk);
    mc_ce = 1'b1;
    mc_oe = 1'b1;

    // CE alone ends the write while WE stays low
    @(negedge clk);
    mc_add = 6'h12;
    drv    = 16'hC3C3;
    drv_en = 1'b1;
    mc_ce  = 1'b0;
    mc_we  = 1'b0;
    repeat (4) @(negedge clk);
    mc_ce = 1'b1;
    repeat (4) @(negedge clk);
    mc_we  = 1'b1;
    drv_en = 1'b0;
    bus_read("ce_only_end", 6'h12, 16'hC3C3);

    // reset during a write strobe: nothing commits
    @(negedge clk);
    mc_add = 6'h13;
    drv    = 16'h9999;
    drv_en = 1'b1;
    mc_ce  = 1'b0;
    mc_we  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    mc_ce  = 1'b1;
    mc_we  = 1'b1;
    repeat (2) @(negedge clk);
    drv_en = 1'b0;
    rst_n  = 1'b1;
    repeat (4) @(negedge clk);
    bus_read("reset_abort_target", 6'h13, 16'h0000);
    bus_read("reset_clears_reg00", 6'h00, 16'h0000);
    bus_read("reset_keeps_id", 6'h3F, 16'h5055);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0",
               sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
